fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 26 ++
 rtl/fetch_unit_if.sv | 26 ++
 rtl/fetch_unit_ifid_reg.sv | 43 ++++
 rtl/fetch_unit.sv | 74 +++++++
 tb/tb_fetch_unit.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared CPU definitions: opcode constants, the NOP word and the fetch FSM
// state encoding used by the fetch stage.
package fetch_unit_pkg;

  // Opcodes live in instr[15:12].
  localparam logic [3:0]  OP_BEQ  = 4'b0100;
  localparam logic [3:0]  OP_BNE  = 4'b0101;
  localparam logic [3:0]  OP_JMP  = 4'b0110;
  localparam logic [3:0]  OP_HALT = 4'b1111;

  // Word presented to ID for a bubble.
  localparam logic [15:0] NOP_WORD = 16'h0000;

  // Instructions are 16 bits wide and the PC is byte addressed.
  localparam logic [15:0] PC_STEP = 16'd2;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

  function automatic logic [3:0] opcode_of(input logic [15:0] instr);
    return instr[15:12];
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch stage bundle: hazard/branch control in, instruction memory port,
// IF/ID pipeline register out. The fetch unit uses the master modport,
// the surrounding pipeline and memory use the slave modport.
interface fetch_if;

  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc;
  logic        ifid_valid;
  logic        halted;

  modport master (
    input  stall, branch_taken, branch_target, imem_rdata,
    output imem_addr, ifid_instr, ifid_pc, ifid_valid, halted
  );

  modport slave (
    output stall, branch_taken, branch_target, imem_rdata,
    input  imem_addr, ifid_instr, ifid_pc, ifid_valid, halted
  );

endinterface

// File: rtl/fetch_unit_ifid_reg.sv
// IF/ID pipeline register. flush inserts a bubble and wins over load;
// with neither asserted the register holds (used for stalls).
module ifid_reg
  import fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        flush_i,
  input  logic [15:0] instr_i,
  input  logic [15:0] pc_i,
  output logic [15:0] instr_o,
  output logic [15:0] pc_o,
  output logic        valid_o
);

  logic [15:0] instr_q;
  logic [15:0] pc_q;
  logic        valid_q;

  // Capture a fetched instruction, insert a bubble, or hold.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q <= NOP_WORD;
      pc_q    <= 16'h0000;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      instr_q <= NOP_WORD;
      valid_q <= 1'b0;
    end else if (load_i) begin
      instr_q <= instr_i;
      pc_q    <= pc_i;
      valid_q <= 1'b1;
    end
  end

  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC and the RUN/HALT fetch FSM and feeds
// the IF/ID register. Per-cycle priority: stall > branch > halt hold > PC+2.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [3:0]  HALT_OP  = OP_HALT
) (
  input logic     clk,
  input logic     rst,
  fetch_if.master bus
);

  fetch_state_e state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic         ifid_load;
  logic         ifid_flush;

  // PC and FSM state registers.
  // NOTE: only real state is reset here; the asynchronous reset forces the
  // PC and FSM immediately, without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      state_q <= ST_RUN;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  // Next PC, next state and IF/ID control, in priority order.
  // NOTE: every signal gets a default before the if-chain so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    pc_d       = pc_q;
    state_d    = state_q;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    if (bus.stall) begin
      // Freeze everything; a branch seen this cycle is dropped.
    end else if (bus.branch_taken) begin
      // Redirect unmodified; also squashes a speculatively fetched halt.
      pc_d       = bus.branch_target;
      ifid_flush = 1'b1;
      state_d    = ST_RUN;
    end else if (state_q == ST_HALT) begin
      ifid_flush = 1'b1;
    end else begin
      ifid_load = 1'b1;
      if (opcode_of(bus.imem_rdata) == HALT_OP) begin
        state_d = ST_HALT;
      end else begin
        pc_d = pc_q + PC_STEP;  // 16-bit wrap is intended
      end
    end
  end

  ifid_reg u_ifid_reg (
    .clk     (clk),
    .rst     (rst),
    .load_i  (ifid_load),
    .flush_i (ifid_flush),
    .instr_i (bus.imem_rdata),
    .pc_i    (pc_q),
    .instr_o (bus.ifid_instr),
    .pc_o    (bus.ifid_pc),
    .valid_o (bus.ifid_valid)
  );

  assign bus.imem_addr = pc_q;
  assign bus.halted    = (state_q == ST_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit. Stimulus pushes the expected IF/ID contents
// into a scoreboard when it issues a fetch; a monitor pops and compares each
// new valid IF/ID word. Direct checks cover PC, halt flag and bubbles.
module tb_fetch_unit;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] instr;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  bit   stall_at_edge = 1'b0;
  bit   halt_en = 1'b0;
  exp_t exp_q[$];

  fetch_if bus();

  fetch_unit #(
    .RESET_PC (16'h0000),
    .HALT_OP  (4'b1111)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Instruction memory: {4'h1, addr[11:0]}, optionally a halt word at 6.
  assign bus.imem_rdata = (halt_en && bus.imem_addr == 16'h0006) ? 16'hF000
                                                                 : {4'h1, bus.imem_addr[11:0]};

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [15:0] pc, input logic [15:0] instr);
    exp_t e;
    e.pc    = pc;
    e.instr = instr;
    exp_q.push_back(e);
  endtask

  // Runs after any same-edge monitor pop.
  task automatic expect_drained(input string name);
    #1;
    check(name, 16'(exp_q.size()), 16'd0);
  endtask

  // Mid-cycle reset pulse; outputs must settle without a clock edge.
  task automatic do_reset();
    @(posedge clk);
    #2;
    bus.stall        = 1'b0;
    bus.branch_taken = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_imem_addr",  bus.imem_addr,  16'h0000);
    check("rst_ifid_instr", bus.ifid_instr, 16'h0000);
    check("rst_ifid_pc",    bus.ifid_pc,    16'h0000);
    check("rst_ifid_valid", 16'(bus.ifid_valid), 16'd0);
    check("rst_halted",     16'(bus.halted),     16'd0);
    #1;
    rst = 1'b0;
  endtask

  always @(posedge clk) stall_at_edge <= bus.stall;

  // Monitor: compare every freshly loaded valid IF/ID word.
  always @(negedge clk) begin
    if (!rst && bus.ifid_valid && !stall_at_edge) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_output: ifid_pc=%h ifid_instr=%h, scoreboard empty",
                 bus.ifid_pc, bus.ifid_instr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_ifid_pc",    bus.ifid_pc,    e.pc);
        check("sb_ifid_instr", bus.ifid_instr, e.instr);
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.stall         = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 16'h0000;

    // Sequential fetch from reset.
    do_reset();
    @(negedge clk); push(16'h0000, 16'h1000);
    @(negedge clk); push(16'h0002, 16'h1002);
    @(negedge clk); push(16'h0004, 16'h1004);
    @(negedge clk);
    check("seq_pc", bus.imem_addr, 16'h0006);
    check("seq_valid", 16'(bus.ifid_valid), 16'd1);
    expect_drained("seq_drained");

    // Branch at PC=4 to 0x0010: one bubble, then target.
    do_reset();
    @(negedge clk); push(16'h0000, 16'h1000);
    @(negedge clk); push(16'h0002, 16'h1002);
    @(negedge clk);
    check("br_pc_before", bus.imem_addr, 16'h0004);
    bus.branch_taken = 1'b1; bus.branch_target = 16'h0010;
    @(negedge clk);
    check("br_bubble_valid", 16'(bus.ifid_valid), 16'd0);
    check("br_bubble_instr", bus.ifid_instr, 16'h0000);
    check("br_pc", bus.imem_addr, 16'h0010);
    bus.branch_taken = 1'b0;
    push(16'h0010, 16'h1010);
    @(negedge clk);
    check("br_target_valid", 16'(bus.ifid_valid), 16'd1);
    expect_drained("br_drained");

    // Stall with branch for two cycles at PC=8, then branch alone.
    do_reset();
    @(negedge clk); push(16'h0000, 16'h1000);
    @(negedge clk); push(16'h0002, 16'h1002);
    @(negedge clk); push(16'h0004, 16'h1004);
    @(negedge clk); push(16'h0006, 16'h1006);
    @(negedge clk);
    check("stall_pc_start", bus.imem_addr, 16'h0008);
    bus.stall = 1'b1; bus.branch_taken = 1'b1; bus.branch_target = 16'h0030;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("stall_pc", bus.imem_addr, 16'h0008);
      check("stall_ifid_pc", bus.ifid_pc, 16'h0006);
      check("stall_ifid_instr", bus.ifid_instr, 16'h1006);
      check("stall_ifid_valid", 16'(bus.ifid_valid), 16'd1);
    end
    bus.stall = 1'b0;
    @(negedge clk);
    check("unstall_br_pc", bus.imem_addr, 16'h0030);
    check("unstall_br_valid", 16'(bus.ifid_valid), 16'd0);
    bus.branch_taken = 1'b0;
    push(16'h0030, 16'h1030);
    @(negedge clk);
    expect_drained("stall_drained");

    // Halt word at PC=6, then branch out of HALT to 0x0020.
    halt_en = 1'b1;
    do_reset();
    @(negedge clk); push(16'h0000, 16'h1000);
    @(negedge clk); push(16'h0002, 16'h1002);
    @(negedge clk); push(16'h0004, 16'h1004);
    @(negedge clk); push(16'h0006, 16'hF000);
    @(negedge clk);
    check("halt_flag", 16'(bus.halted), 16'd1);
    check("halt_pc", bus.imem_addr, 16'h0006);
    @(negedge clk);
    check("halt_hold_pc", bus.imem_addr, 16'h0006);
    check("halt_bubble_valid", 16'(bus.ifid_valid), 16'd0);
    check("halt_bubble_instr", bus.ifid_instr, 16'h0000);
    check("halt_hold_flag", 16'(bus.halted), 16'd1);
    bus.branch_taken = 1'b1; bus.branch_target = 16'h0020;
    @(negedge clk);
    check("unhalt_flag", 16'(bus.halted), 16'd0);
    check("unhalt_pc", bus.imem_addr, 16'h0020);
    bus.branch_taken = 1'b0;
    push(16'h0020, 16'h1020);
    @(negedge clk);
    expect_drained("unhalt_drained");

    // Reach HALT again, then reset between edges; fetch restarts at 0.
    do_reset();
    @(negedge clk); push(16'h0000, 16'h1000);
    @(negedge clk); push(16'h0002, 16'h1002);
    @(negedge clk); push(16'h0004, 16'h1004);
    @(negedge clk); push(16'h0006, 16'hF000);
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_halted", 16'(bus.halted), 16'd1);
    expect_drained("pre_rst_drained");
    do_reset();
    @(negedge clk); push(16'h0000, 16'h1000);
    @(negedge clk);
    check("post_rst_pc", bus.imem_addr, 16'h0002);
    expect_drained("post_rst_drained");
    halt_en = 1'b0;

    // PC wrap at 0xFFFE, then an odd branch target passed through.
    do_reset();
    @(negedge clk);
    bus.branch_taken = 1'b1; bus.branch_target = 16'hFFFE;
    @(negedge clk);
    check("wrap_pc_start", bus.imem_addr, 16'hFFFE);
    bus.branch_taken = 1'b0;
    push(16'hFFFE, 16'h1FFE);
    @(negedge clk);
    check("wrap_pc", bus.imem_addr, 16'h0000);
    check("wrap_ifid_pc", bus.ifid_pc, 16'hFFFE);
    bus.branch_taken = 1'b1; bus.branch_target = 16'h0013;
    @(negedge clk);
    check("odd_target_pc", bus.imem_addr, 16'h0013);
    bus.branch_taken = 1'b0;
    push(16'h0013, 16'h1013);
    @(negedge clk);
    check("odd_next_pc", bus.imem_addr, 16'h0015);
    expect_drained("odd_drained");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
